ws2812_frame_sequencer: RTL and testbench

Schedules and drives the WS2812 single-wire output from decoded 24-bit pixel words produced upstream by the APA102 receive path. Buffers pixels in a small FIFO and serialises them MSB-first with programmable high and low bit timing. Manages frame boundaries by inserting the WS2812 latch (reset) gap. Sits between the APA102 decoder and the uo_out[0] pin in the top-level.

---
 rtl/ws2812_frame_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
// Buffers 24-bit GRB pixel words in a small FIFO and serialises them MSB-first
// onto the WS2812 data line. Each bit has programmable high and total times.
// A latch (reset) gap of low line is inserted at frame boundaries. If the FIFO
// runs dry mid-frame, a low gap is held until either more pixels arrive or the
// gap grows long enough to latch the frame.
module ws2812_frame_sequencer #(
  parameter int T0H_CYC    = 18,
  parameter int T1H_CYC    = 35,
  parameter int TBIT_CYC   = 63,
  parameter int RESET_CYC  = 2600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        frame_end,
  output logic        ws_out,
  output logic        busy,
  output logic        latch_done,
  output logic        underrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CYC_W = $clog2(TBIT_CYC);
  localparam int GAP_W = $clog2(RESET_CYC + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] T0_LAST    = CYC_W'(T0H_CYC - 1);
  localparam logic [CYC_W-1:0] T1_LAST    = CYC_W'(T1H_CYC - 1);
  localparam logic [CYC_W-1:0] TBIT_LAST  = CYC_W'(TBIT_CYC - 1);
  localparam logic [GAP_W-1:0] RESET_LAST = GAP_W'(RESET_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_RESET
  } state_t;

  // Pixel FIFO storage and bookkeeping
  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;
  logic [23:0]      head_word;

  // Serialiser state
  state_t           state_reg;
  logic [23:0]      shift_reg;
  logic [4:0]       bit_idx_reg;
  logic [CYC_W-1:0] cyc_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             ws_out_reg;
  logic             latch_done_reg;
  logic             underrun_reg;
  logic             end_pending_reg;
  logic             frame_active_reg;

  logic             last_bit;
  logic [CYC_W-1:0] thigh_last;

  assign fifo_nonempty = (count_reg != '0);
  assign pix_ready     = (count_reg != FULL_CNT);
  assign push          = pix_valid && pix_ready;
  assign head_word     = fifo_mem[rd_ptr_reg];

  assign last_bit   = (bit_idx_reg == 5'd0) && (cyc_reg == TBIT_LAST);
  // The bit on the wire is always the MSB of the shifter.
  assign thigh_last = shift_reg[23] ? T1_LAST : T0_LAST;

  assign ws_out     = ws_out_reg;
  assign latch_done = latch_done_reg;
  assign underrun   = underrun_reg;
  assign busy       = (state_reg != ST_IDLE) || fifo_nonempty;

  // Pop request: taken only on a registered non-empty FIFO, so a simultaneous
  // push can never be popped in the same cycle it is written.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      ST_IDLE: pop = fifo_nonempty;
      ST_SEND: pop = last_bit && fifo_nonempty;
      ST_GAP:  pop = fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO data write; storage needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= pix_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame sequencer: bit timing, frame boundary tracking and latch gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      shift_reg        <= '0;
      bit_idx_reg      <= '0;
      cyc_reg          <= '0;
      gap_cnt_reg      <= '0;
      ws_out_reg       <= 1'b0;
      latch_done_reg   <= 1'b0;
      underrun_reg     <= 1'b0;
      end_pending_reg  <= 1'b0;
      frame_active_reg <= 1'b0;
    end else begin
      latch_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;

      // A frame_end only means something once a frame has content; the
      // latch completion below overrides it when both land together.
      if (frame_end && (frame_active_reg || fifo_nonempty || push)) begin
        end_pending_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (fifo_nonempty) begin
            shift_reg        <= head_word;
            bit_idx_reg      <= 5'd23;
            cyc_reg          <= '0;
            ws_out_reg       <= 1'b1;
            frame_active_reg <= 1'b1;
            state_reg        <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (cyc_reg == TBIT_LAST) begin
            if (bit_idx_reg != 5'd0) begin
              shift_reg   <= {shift_reg[22:0], 1'b0};
              bit_idx_reg <= bit_idx_reg - 5'd1;
              cyc_reg     <= '0;
              ws_out_reg  <= 1'b1;
            end else if (fifo_nonempty) begin
              // Next pixel follows with no gap.
              shift_reg   <= head_word;
              bit_idx_reg <= 5'd23;
              cyc_reg     <= '0;
              ws_out_reg  <= 1'b1;
            end else if (end_pending_reg) begin
              gap_cnt_reg <= '0;
              ws_out_reg  <= 1'b0;
              state_reg   <= ST_RESET;
            end else begin
              gap_cnt_reg  <= '0;
              ws_out_reg   <= 1'b0;
              underrun_reg <= 1'b1;
              state_reg    <= ST_GAP;
            end
          end else begin
            // Line stays high while the next cycle index is below THIGH.
            cyc_reg    <= cyc_reg + CYC_W'(1);
            ws_out_reg <= (cyc_reg < thigh_last);
          end
        end

        ST_GAP: begin
          ws_out_reg <= 1'b0;
          if (fifo_nonempty) begin
            shift_reg   <= head_word;
            bit_idx_reg <= 5'd23;
            cyc_reg     <= '0;
            ws_out_reg  <= 1'b1;
            state_reg   <= ST_SEND;
          end else if (gap_cnt_reg == RESET_LAST) begin
            latch_done_reg   <= 1'b1;
            end_pending_reg  <= 1'b0;
            frame_active_reg <= 1'b0;
            state_reg        <= ST_IDLE;
          end else begin
            // The gap already spent counts toward the latch time.
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            if (end_pending_reg) begin
              state_reg <= ST_RESET;
            end
          end
        end

        ST_RESET: begin
          ws_out_reg <= 1'b0;
          if (gap_cnt_reg == RESET_LAST) begin
            latch_done_reg   <= 1'b1;
            end_pending_reg  <= 1'b0;
            frame_active_reg <= 1'b0;
            state_reg        <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// tb_ws2812_frame_sequencer
// Decodes the WS2812 line back into pixel words and compares them, together
// with bit spacing, latch and underrun timing, against expectations derived
// from the pushed pixels and the frame_end timing.
`timescale 1ns/1ps
module tb_ws2812_frame_sequencer;

  localparam int T0H     = 18;
  localparam int T1H     = 35;
  localparam int TBIT    = 63;
  localparam int RST_GAP = 2600;
  localparam int PIX_CYC = 24 * TBIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        frame_end = 1'b0;
  logic        pix_ready;
  logic        ws_out;
  logic        busy;
  logic        latch_done;
  logic        underrun;

  ws2812_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_end  (frame_end),
    .ws_out     (ws_out),
    .busy       (busy),
    .latch_done (latch_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N (and before the next) cycle == N.
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s observed=%0d required=%0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference expectations filled by the driver, consumed by the line decoder.
  logic [23:0] exp_q[$];
  int nbits = 0;
  int hi_start = -1;
  int last_rise = -1000000;
  int pix_start = -1000000;
  int last_bit_end = -1000000;
  int latch_count = 0;
  int underrun_count = 0;
  int last_latch = -1;
  int pix_done = 0;
  int rise_count = 0;
  logic prev_ws = 1'b0;
  logic rst_d = 1'b0;

  // Line decoder: measures every high pulse and matches it to the expected bit.
  initial begin
    logic [23:0] cur;
    forever begin
      @(negedge clk);
      if (!rst_n || !rst_d) begin
        nbits = 0;
        hi_start = -1;
        last_rise = -1000000;
        last_bit_end = -1000000;
        exp_q.delete();
      end else begin
        if (ws_out && !prev_ws) begin
          if (nbits != 0) check_val("bit_period", cycle - last_rise, TBIT);
          else pix_start = cycle;
          last_rise = cycle;
          hi_start = cycle;
          rise_count++;
        end
        if (!ws_out && prev_ws && hi_start >= 0) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_bit", exp_q.size(), 1);
          end else begin
            cur = exp_q[0];
            check_val("hi_width", cycle - hi_start, cur[23 - nbits] ? T1H : T0H);
            nbits++;
            if (nbits == 24) begin
              void'(exp_q.pop_front());
              nbits = 0;
              last_bit_end = last_rise + TBIT;
              pix_done++;
            end
          end
          hi_start = -1;
        end
        if (latch_done) begin
          check_val("latch_time", cycle, last_bit_end + RST_GAP);
          latch_count++;
          last_latch = cycle;
        end
        if (underrun) begin
          check_val("underrun_time", cycle, last_bit_end);
          underrun_count++;
        end
      end
      prev_ws = ws_out;
      rst_d = rst_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers a word until accepted; acc_edge is the rising edge of the transfer.
  task automatic push_pixel(input logic [23:0] d, output int acc_edge);
    bit ok;
    int tries;
    ok = 1'b0;
    tries = 0;
    acc_edge = -1;
    pix_data = d;
    pix_valid = 1'b1;
    while (!ok && tries < 20000) begin
      @(negedge clk);
      ok = pix_ready;
      if (ok) exp_q.push_back(d);
      @(posedge clk);
      #1;
      tries++;
    end
    pix_valid = 1'b0;
    if (ok) acc_edge = cycle;
    check_val("push_accept", ok, 1);
  endtask

  task automatic pulse_frame_end(output int fe_edge);
    frame_end = 1'b1;
    @(posedge clk);
    #1;
    frame_end = 1'b0;
    fe_edge = cycle;
  endtask

  task automatic wait_latch(input int target, input int budget);
    int n;
    n = 0;
    while (latch_count < target && n < budget) begin
      tick(1);
      n++;
    end
    check_val("latch_seen", latch_count, target);
  endtask

  task automatic wait_pix(input int target, input int budget);
    int n;
    n = 0;
    while (pix_done < target && n < budget) begin
      tick(1);
      n++;
    end
    check_val("pixel_seen", pix_done, target);
  endtask

  task automatic wait_cycle(input int target);
    while (cycle < target) tick(1);
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k5, fe, la, ur, rc, e, n, d;
    logic [23:0] w;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_val("rst_ws_out", ws_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pix_ready", pix_ready, 1);
    check_val("rst_latch_done", latch_done, 0);
    check_val("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: single pixel 0xA50000
    ur = underrun_count;
    push_pixel(24'hA50000, k);
    pulse_frame_end(fe);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    check_val("s1_first_rise", pix_start, k + 1);
    check_val("s1_last_bit_end", last_bit_end, k + 1 + PIX_CYC);
    wait_latch(latch_count + 1, RST_GAP + 200);
    check_val("s1_latch_edge", last_latch, k + 1 + PIX_CYC + RST_GAP);
    tick(2);
    check_val("s1_busy_after", busy, 0);
    check_val("s1_no_underrun", underrun_count, ur);
    $display("txn s1 single pixel accepted at %0d latched at %0d", k, last_latch);

    // 2: back-to-back pixels
    ur = underrun_count;
    rc = rise_count;
    push_pixel(24'($urandom), k);
    push_pixel(24'($urandom), k2);
    check_val("s2_consecutive", k2, k + 1);
    pulse_frame_end(fe);
    wait_latch(latch_count + 1, 2 * PIX_CYC + RST_GAP + 200);
    check_val("s2_rises", rise_count - rc, 48);
    check_val("s2_last_rise", last_rise, k + 1 + 47 * TBIT);
    check_val("s2_no_underrun", underrun_count, ur);
    $display("txn s2 two pixels from edge %0d", k);

    // 3: FIFO fills while the previous frame latches
    push_pixel(24'($urandom), k);
    pulse_frame_end(fe);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    wait_cycle(last_bit_end + 6);
    push_pixel(24'($urandom), k);
    for (int i = 1; i < 4; i++) begin
      push_pixel(24'($urandom), k2);
      check_val("s3_fill_edge", k2, k + i);
    end
    check_val("s3_full", pix_ready, 0);
    push_pixel(24'($urandom), k5);
    check_val("s3_fifth_edge", k5, last_latch + 2);
    pulse_frame_end(fe);
    wait_latch(latch_count + 1, 5 * PIX_CYC + RST_GAP + 200);
    check_val("s3_drained", exp_q.size(), 0);
    $display("txn s3 fifth pixel accepted at %0d", k5);

    // 4: underrun then resume, then underrun that latches
    ur = underrun_count;
    la = latch_count;
    push_pixel(24'($urandom), k);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    n = 0;
    while (underrun_count == ur && n < 200) begin
      tick(1);
      n++;
    end
    check_val("s4_underrun", underrun_count, ur + 1);
    e = last_bit_end;
    wait_cycle(e + 998);
    push_pixel(24'($urandom), k2);
    check_val("s4_b_edge", k2, e + 999);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    check_val("s4_low_gap", pix_start - e, 1000);
    check_val("s4_no_latch", latch_count, la);
    pulse_frame_end(fe);
    wait_latch(la + 1, RST_GAP + 200);
    push_pixel(24'($urandom), k);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    wait_latch(la + 2, RST_GAP + 200);
    check_val("s4_latch_after_gap", last_latch, last_bit_end + RST_GAP);
    check_val("s4_underruns", underrun_count, ur + 2);
    $display("txn s4 underrun gap resumed at %0d", pix_start);

    // 5: reset mid-frame
    push_pixel(24'($urandom), k);
    push_pixel(24'($urandom), k2);
    push_pixel(24'($urandom), k2);
    wait_cycle(k + 500);
    la = latch_count;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_val("s5_ws_out", ws_out, 0);
    check_val("s5_busy", busy, 0);
    check_val("s5_pix_ready", pix_ready, 1);
    check_val("s5_latch_done", latch_done, 0);
    tick(RST_GAP + 200);
    check_val("s5_no_latch", latch_count, la);
    check_val("s5_idle_line", ws_out, 0);
    push_pixel(24'($urandom), k);
    pulse_frame_end(fe);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    check_val("s5_fresh_start", pix_start, k + 1);
    wait_latch(la + 1, RST_GAP + 200);
    $display("txn s5 reset mid-frame, fresh pixel at %0d", k);

    // 6: frame_end in IDLE with empty FIFO is ignored
    la = latch_count;
    ur = underrun_count;
    rc = rise_count;
    pulse_frame_end(fe);
    tick(RST_GAP + 200);
    check_val("s6_ws_out", ws_out, 0);
    check_val("s6_busy", busy, 0);
    check_val("s6_no_latch", latch_count, la);
    check_val("s6_no_rise", rise_count, rc);
    push_pixel(24'($urandom), k);
    wait_pix(pix_done + 1, PIX_CYC + 100);
    wait_latch(la + 1, RST_GAP + 300);
    check_val("s6_end_not_pending", underrun_count, ur + 1);
    $display("txn s6 ignored frame_end at %0d", fe);

    // Randomised frames with frame_end at a random point
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 4);
      ur = underrun_count;
      la = latch_count;
      for (int i = 0; i < n; i++) begin
        w = 24'($urandom);
        push_pixel(w, k);
      end
      d = $urandom_range(0, n * PIX_CYC + 300);
      tick(d);
      pulse_frame_end(fe);
      wait_latch(la + 1, n * PIX_CYC + RST_GAP + 2000);
      check_val("rnd_underrun", underrun_count - ur, (fe >= last_bit_end) ? 1 : 0);
      check_val("rnd_drained", exp_q.size(), 0);
      $display("txn rnd frame %0d pixels=%0d frame_end=%0d last_bit_end=%0d", f, n, fe, last_bit_end);
    end

    tick(2);
    check_val("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
